// File: rtl/inst_fetch.sv
// Instruction-fetch stage: one outstanding request to a variable-latency
// instruction memory, IF/ID register with a one-entry skid buffer.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_stall,
  input  logic        flush,
  input  logic        stall_id,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [31:0] req_pc_r;
  logic        skid_valid_r;
  logic [31:0] skid_pc_r;
  logic [31:0] skid_inst_r;
  logic        id_valid_r;
  logic [31:0] id_pc_r;
  logic [31:0] id_inst_r;

  logic        slot_free_s;
  logic        resp_s;
  logic        issue_ok_s;
  logic        req_s;
  logic        accept_s;

  // Issue / accept decode and PC hold
  always_comb begin
    slot_free_s = !id_valid_r || !stall_id;
    resp_s      = (state_r == ST_WAIT) && imem_rvalid;
    issue_ok_s  = (state_r == ST_IDLE) || (resp_s && slot_free_s);
    req_s       = !rst && !flush && !skid_valid_r && issue_ok_s;
    accept_s    = req_s && imem_ready;
  end

  assign pc_plus4    = pc + 32'd4;
  assign imem_req    = req_s;
  assign imem_addr   = pc;
  assign fetch_stall = rst || (!flush && !accept_s);
  assign id_valid    = id_valid_r;
  assign id_pc       = id_pc_r;
  assign id_inst     = id_inst_r;

  // Next-state logic; a flushed in-flight request must still be drained in DROP
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          if (imem_rvalid) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_DROP;
          end
        end else if (imem_rvalid) begin
          if (accept_s) begin
            state_s = ST_WAIT;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DROP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // PC of the outstanding request
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_r <= 32'd0;
    end else if (accept_s) begin
      req_pc_r <= pc;
    end else begin
      req_pc_r <= req_pc_r;
    end
  end

  // IF/ID register and skid buffer; flush outranks stall and responses
  always_ff @(posedge clk) begin
    if (rst) begin
      id_valid_r   <= 1'b0;
      id_pc_r      <= 32'd0;
      id_inst_r    <= NOP_INST;
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 32'd0;
      skid_inst_r  <= NOP_INST;
    end else if (flush) begin
      id_valid_r   <= 1'b0;
      skid_valid_r <= 1'b0;
    end else if (skid_valid_r && !stall_id) begin
      id_valid_r   <= 1'b1;
      id_pc_r      <= skid_pc_r;
      id_inst_r    <= skid_inst_r;
      skid_valid_r <= 1'b0;
    end else if (resp_s && slot_free_s) begin
      id_valid_r <= 1'b1;
      id_pc_r    <= req_pc_r;
      id_inst_r  <= imem_rdata;
    end else if (resp_s) begin
      skid_valid_r <= 1'b1;
      skid_pc_r    <= req_pc_r;
      skid_inst_r  <= imem_rdata;
    end else if (!stall_id) begin
      id_valid_r <= 1'b0;
    end else begin
      id_valid_r <= id_valid_r;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: vector tables, directed corner
// sequences, and a randomized run against a queue-based scoreboard.
module tb_inst_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_stall;
  logic        flush;
  logic        stall_id;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  inst_fetch dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_plus4(pc_plus4), .fetch_stall(fetch_stall),
    .flush(flush), .stall_id(stall_id), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [31:0] p, input logic rdy, input logic rv,
                     input logic [31:0] rd, input logic st, input logic fl);
    pc = p; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    stall_id = st; flush = fl;
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; flush = 1'b0; stall_id = 1'b0; imem_ready = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  // Brings pc 0,4 into IF/ID and parks the pc 8 response in the skid buffer.
  task automatic fill_skid;
    drv(32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick;
    drv(32'h4, 1'b1, 1'b1, 32'h0 ^ KEY, 1'b0, 1'b0); tick;
    chk("skid_pre_pc0", id_pc, 32'h0);
    drv(32'h8, 1'b1, 1'b1, 32'h4 ^ KEY, 1'b0, 1'b0); tick;
    chk("skid_pre_pc4", id_pc, 32'h4);
    drv(32'hC, 1'b1, 1'b1, 32'h8 ^ KEY, 1'b1, 1'b0);
    chk("skid_fill_req", imem_req, 32'd0);
    chk("skid_fill_stall", fetch_stall, 32'd1);
    tick;
    chk("skid_fill_vld", id_valid, 32'd1);
    chk("skid_fill_pc", id_pc, 32'h4);
    chk("skid_fill_inst", id_inst, 32'h4 ^ KEY);
    drv(32'hC, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("skid_hold_req", imem_req, 32'd0);
    tick;
    chk("skid_hold_pc", id_pc, 32'h4);
  endtask

  typedef struct {
    logic [31:0] pc;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_req;
    logic        e_stall;
    logic        e_vld;
    logic [31:0] e_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] e_p4;
  } p4_t;

  vec_t        tbl[7];
  p4_t         p4tbl[5];
  logic [31:0] exp_q[$];

  initial begin
    logic        busy, rv, acc, prev_hold, idv_b, st_b, fl_b, fs_b;
    logic [31:0] maddr, prev_addr, pc_b, inst_b, epc;
    int          cnt, delivered;

    tbl[0] = '{32'h00, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{32'h04, 1'b1, 1'b1, 32'h00 ^ KEY, 1'b1, 1'b0, 1'b1, 32'h00};
    tbl[2] = '{32'h08, 1'b1, 1'b1, 32'h04 ^ KEY, 1'b1, 1'b0, 1'b1, 32'h04};
    tbl[3] = '{32'h0C, 1'b1, 1'b1, 32'h08 ^ KEY, 1'b1, 1'b0, 1'b1, 32'h08};
    tbl[4] = '{32'h10, 1'b0, 1'b1, 32'h0C ^ KEY, 1'b1, 1'b1, 1'b1, 32'h0C};
    tbl[5] = '{32'h10, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{32'h14, 1'b1, 1'b1, 32'h10 ^ KEY, 1'b1, 1'b0, 1'b1, 32'h10};

    p4tbl[0] = '{32'h0000_0000, 32'h0000_0004};
    p4tbl[1] = '{32'h0000_0004, 32'h0000_0008};
    p4tbl[2] = '{32'h7FFF_FFFC, 32'h8000_0000};
    p4tbl[3] = '{32'hFFFF_FFFC, 32'h0000_0000};
    p4tbl[4] = '{32'h1234_5678, 32'h1234_567C};

    pc = 32'd0;
    do_reset;
    chk("rst_id_valid", id_valid, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, NOP);

    // Back-to-back fetch
    for (int i = 0; i < 7; i++) begin
      drv(tbl[i].pc, tbl[i].rdy, tbl[i].rv, tbl[i].rd, 1'b0, 1'b0);
      chk($sformatf("b2b_req[%0d]", i), imem_req, {31'd0, tbl[i].e_req});
      chk($sformatf("b2b_stall[%0d]", i), fetch_stall, {31'd0, tbl[i].e_stall});
      chk($sformatf("b2b_addr[%0d]", i), imem_addr, tbl[i].pc);
      tick;
      chk($sformatf("b2b_vld[%0d]", i), id_valid, {31'd0, tbl[i].e_vld});
      if (tbl[i].e_vld) begin
        chk($sformatf("b2b_pc[%0d]", i), id_pc, tbl[i].e_pc);
        chk($sformatf("b2b_inst[%0d]", i), id_inst, tbl[i].e_pc ^ KEY);
      end
    end

    for (int i = 0; i < 5; i++) begin
      drv(p4tbl[i].pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk($sformatf("p4[%0d]", i), pc_plus4, p4tbl[i].e_p4);
    end

    // Latency 3 with two not-ready cycles first
    do_reset;
    for (int k = 0; k < 2; k++) begin
      drv(32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("lat_req_held", imem_req, 32'd1);
      chk("lat_addr_stable", imem_addr, 32'h100);
      chk("lat_stall_nrdy", fetch_stall, 32'd1);
      chk("lat_p4", pc_plus4, 32'h104);
      tick;
      chk("lat_vld_nrdy", id_valid, 32'd0);
    end
    drv(32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("lat_accept_stall", fetch_stall, 32'd0);
    tick;
    for (int k = 0; k < 2; k++) begin
      drv(32'h104, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("lat_wait_req", imem_req, 32'd0);
      chk("lat_wait_stall", fetch_stall, 32'd1);
      tick;
      chk("lat_wait_vld", id_valid, 32'd0);
    end
    drv(32'h104, 1'b1, 1'b1, 32'h100 ^ KEY, 1'b0, 1'b0);
    chk("lat_rv_req", imem_req, 32'd1);
    chk("lat_rv_stall", fetch_stall, 32'd0);
    tick;
    chk("lat_rv_vld", id_valid, 32'd1);
    chk("lat_rv_pc", id_pc, 32'h100);
    chk("lat_rv_inst", id_inst, 32'h100 ^ KEY);
    drv(32'h108, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick;
    chk("lat_one_write", id_valid, 32'd0);

    // Skid buffer drain
    do_reset;
    fill_skid;
    drv(32'hC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("skid_drain_req", imem_req, 32'd0);
    tick;
    chk("skid_drain_vld", id_valid, 32'd1);
    chk("skid_drain_pc", id_pc, 32'h8);
    chk("skid_drain_inst", id_inst, 32'h8 ^ KEY);
    drv(32'hC, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("skid_next_req", imem_req, 32'd1);
    chk("skid_next_addr", imem_addr, 32'hC);
    tick;

    // Flush in WAIT
    do_reset;
    drv(32'h10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick;
    drv(32'h14, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    chk("fw_flush_req", imem_req, 32'd0);
    chk("fw_flush_stall", fetch_stall, 32'd0);
    tick;
    chk("fw_vld", id_valid, 32'd0);
    drv(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fw_drop_req", imem_req, 32'd0);
    tick;
    drv(32'h40, 1'b1, 1'b1, 32'h10 ^ KEY, 1'b0, 1'b0);
    chk("fw_drop_rv_req", imem_req, 32'd0);
    tick;
    chk("fw_discard_vld", id_valid, 32'd0);
    drv(32'h40, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fw_redirect_req", imem_req, 32'd1);
    chk("fw_redirect_addr", imem_addr, 32'h40);
    tick;

    // Flush with skid full, then flush coincident with rvalid in WAIT
    do_reset;
    fill_skid;
    drv(32'hC, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    chk("fc_req", imem_req, 32'd0);
    tick;
    chk("fc_vld", id_valid, 32'd0);
    drv(32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fc_idle_req", imem_req, 32'd1);
    chk("fc_idle_addr", imem_addr, 32'h80);
    tick;
    chk("fc_skid_gone", id_valid, 32'd0);
    drv(32'h84, 1'b1, 1'b1, 32'h80 ^ KEY, 1'b0, 1'b1);
    chk("fc_rv_req", imem_req, 32'd0);
    tick;
    chk("fc_rv_vld", id_valid, 32'd0);
    drv(32'h90, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("fc_rv_idle_req", imem_req, 32'd1);
    chk("fc_rv_idle_addr", imem_addr, 32'h90);
    tick;

    // Reset while WAIT, stale response afterwards
    do_reset;
    drv(32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0); tick;
    rst = 1'b1;
    drv(32'h20, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rw_rst_req", imem_req, 32'd0);
    chk("rw_rst_stall", fetch_stall, 32'd1);
    tick;
    rst = 1'b0;
    drv(32'h20, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rw_stale_req", imem_req, 32'd1);
    chk("rw_stale_addr", imem_addr, 32'h20);
    tick;
    chk("rw_stale_vld", id_valid, 32'd0);
    chk("rw_stale_inst", id_inst, NOP);
    drv(32'h20, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rw_restart_stall", fetch_stall, 32'd0);
    tick;
    drv(32'h24, 1'b0, 1'b1, 32'h20 ^ KEY, 1'b0, 1'b0); tick;
    chk("rw_restart_vld", id_valid, 32'd1);
    chk("rw_restart_pc", id_pc, 32'h20);

    // Randomized run: memory with latency 1..3, PC stage, in-order scoreboard
    do_reset;
    pc = 32'd0; busy = 1'b0; cnt = 0; maddr = 32'd0;
    prev_hold = 1'b0; prev_addr = 32'd0; delivered = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rv = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) rv = 1'b1;
      end
      imem_rvalid = rv;
      imem_rdata  = rv ? (maddr ^ KEY) : $urandom();
      imem_ready  = ($urandom_range(0, 9) < 7);
      stall_id    = ($urandom_range(0, 9) < 3);
      flush       = ($urandom_range(0, 19) == 0);
      #1;
      chk("rnd_p4", pc_plus4, pc + 32'd4);
      chk("rnd_stall", fetch_stall, {31'd0, !flush && !(imem_req && imem_ready)});
      if (flush) chk("rnd_flush_req", imem_req, 32'd0);
      if (imem_req) chk("rnd_addr", imem_addr, pc);
      if (prev_hold && !flush) begin
        chk("rnd_req_held", imem_req, 32'd1);
        chk("rnd_addr_held", imem_addr, prev_addr);
      end
      acc = imem_req && imem_ready;
      if (acc) chk("rnd_one_outstanding", {31'd0, busy && !rv}, 32'd0);
      if (rv) busy = 1'b0;
      if (flush) exp_q.delete();
      if (acc) begin
        busy = 1'b1; cnt = $urandom_range(1, 3); maddr = pc;
        exp_q.push_back(pc);
      end
      idv_b = id_valid; st_b = stall_id; pc_b = id_pc; inst_b = id_inst;
      fl_b = flush; fs_b = fetch_stall;
      prev_hold = imem_req && !imem_ready && !flush;
      prev_addr = imem_addr;
      tick;
      if (fl_b) begin
        chk("rnd_flush_vld", id_valid, 32'd0);
      end else if (!idv_b || !st_b) begin
        if (id_valid) begin
          if (exp_q.size() == 0) begin
            chk("rnd_unexpected_vld", id_valid, 32'd0);
          end else begin
            epc = exp_q.pop_front();
            chk("rnd_id_pc", id_pc, epc);
            chk("rnd_id_inst", id_inst, epc ^ KEY);
            delivered++;
          end
        end
      end else begin
        chk("rnd_hold_vld", id_valid, 32'd1);
        chk("rnd_hold_pc", id_pc, pc_b);
        chk("rnd_hold_inst", id_inst, inst_b);
      end
      if (fl_b) pc = $urandom() & 32'hFFFF_FFFC;
      else if (!fs_b) pc = pc + 32'd4;
    end
    chk("rnd_progress", {31'd0, delivered > 100}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage directly downstream of the PC register in the five-stage pipeline. It takes the current PC, issues at most one outstanding request to a variable-latency instruction memory, and returns `pc_plus4` and the PC hold signal (`fetch_stall`, wired to the PC stage's `stall_if`). Fetched words are written into the IF/ID pipeline register, with a one-entry skid buffer for responses that arrive while ID is stalled. Branch redirects (`flush`) kill both buffered and in-flight instructions.

## Interface
- No parameters; XLEN fixed at 32.
- **Clock and reset** (already decided):
  - `clk` in 1: single clock, all state updates on the rising edge.
  - `rst` in 1: synchronous, active-high.
- **PC stage:**
  - `pc` in 32: current PC from the PC stage.
  - `pc_plus4` out 32: `pc + 4`, combinational, wraps mod 2^32.
  - `fetch_stall` out 1: PC must hold; drives the PC stage's `stall_if`.
- **Pipeline control:**
  - `flush` in 1: redirect; the PC stage loads `new_pc` this cycle.
  - `stall_id` in 1: ID stage holds IF/ID.
- **Instruction memory:**
  - `imem_req` out 1: request valid.
  - `imem_addr` out 32: request address, equal to `pc`.
  - `imem_ready` in 1: request accepted this cycle.
  - `imem_rvalid` in 1: read data valid.
  - `imem_rdata` in 32: instruction word.
- **IF/ID register:**
  - `id_valid` out 1: IF/ID holds a live instruction.
  - `id_pc` out 32: PC of the IF/ID instruction.
  - `id_inst` out 32: IF/ID instruction word.

## Operation
- **States:**
  - IDLE: no outstanding request.
  - WAIT: one outstanding request, response kept.
  - DROP: one outstanding request, response discarded.
- **Registers:** `req_pc` (PC of the outstanding request), `skid_valid`, `skid_pc`, `skid_inst`.
- **Slot free:** `slot_free = !id_valid || !stall_id`.
- **Issue:**
  - `imem_req = !rst && !flush && !skid_valid && (state==IDLE || (state==WAIT && imem_rvalid && slot_free))`.
  - Accept: `imem_req && imem_ready`. On accept, `req_pc <= pc` and next state is WAIT.
  - `imem_req` stays high with a stable `imem_addr` until accepted.
- **PC hold:** `fetch_stall = rst || (!flush && !(imem_req && imem_ready))`. It is low on a flush cycle, so the PC always takes the redirect.
- **Response in WAIT** (`imem_rvalid`, no flush):
  - If `slot_free`: IF/ID <= {1, `req_pc`, `imem_rdata`}.
  - Otherwise the response goes to the skid buffer.
  - Next state is WAIT if a new request was accepted this cycle, else IDLE.
- **Skid drain:** when `skid_valid && !stall_id`, IF/ID <= skid contents and `skid_valid <= 0`. No request issues while `skid_valid`, so skid drain and a fresh response never collide.
- **IF/ID update when nothing is delivered:**
  - `!stall_id`: `id_valid <= 0` (bubble).
  - `stall_id`: IF/ID holds.
- **Flush** (priority over `stall_id` and responses):
  - `id_valid <= 0`, `skid_valid <= 0`.
  - WAIT with no `imem_rvalid`: go to DROP.
  - WAIT with `imem_rvalid`: drop the data, go to IDLE.
  - DROP: stay in DROP.
  - IDLE: stay in IDLE.
- **DROP:** no request. On `imem_rvalid`, discard the data and go to IDLE; the next request issues the following cycle.
- **Stray response:** `imem_rvalid` in IDLE is ignored.
- **Reset values:** state IDLE; `id_valid` 0; `id_pc` 0; `id_inst` 0x00000013 (NOP); `skid_valid` 0; `req_pc` 0.
- **Reset mid-operation:** any outstanding request is forgotten. A response arriving after reset lands in IDLE and is ignored.

## Timing
- **Best case, `imem_ready`=1 and `rvalid` one cycle after accept:** one instruction per cycle. The instruction requested in cycle N is in IF/ID in cycle N+2.
- **Memory latency L ≥ 1 cycles:** `id_valid` is first set L+1 cycles after accept. `fetch_stall` is high for cycles N+1 … N+L-1 (none when L=1); it is low on the `rvalid` cycle, where the back-to-back issue happens.
- **Flush:** takes effect the next edge. The first redirected request issues the cycle after flush in IDLE, or the cycle after the discarded `rvalid` in DROP.
- **Skid:** holds at most one entry. It drains on the first edge with `stall_id` low; the next request issues the cycle after the drain.

## Test plan
- **Back-to-back:** reset; memory with `imem_ready`=1, `rvalid` next cycle, `rdata` = addr ^ 0xA5A50000. Required: `id_pc` 0, 4, 8 on consecutive cycles with `id_valid`=1 and `id_inst` matching. `fetch_stall`=0 after the first accept.
- **Latency 3:** `imem_ready` low for 2 cycles, then latency 3. Required: `imem_req` held with `imem_addr` stable, `fetch_stall`=1 throughout, exactly one IF/ID write per accepted request, `pc_plus4` = `pc` + 4. Also drive `pc` = 0xFFFFFFFC and check `pc_plus4` = 0x00000000.
- **Skid:** hold `stall_id`=1 while IF/ID holds pc 4 and the response for pc 8 arrives. Required: `imem_req`=0, IF/ID unchanged. On `stall_id`=0, IF/ID = pc 8 the next cycle, and the pc 12 request issues in that same cycle.
- **Flush in WAIT:** latency 3, flush one cycle after accept at pc 0x10, PC redirected to 0x40. Required: `id_valid`=0, the 0x10 response is discarded, and the next request is to 0x40 the cycle after `rvalid`.
- **Flush coincident:** flush on the same cycle as `rvalid`, with the skid full. Required: both the response and the skid entry are discarded, `imem_req`=0 that cycle, IDLE next cycle.
- **Reset in WAIT:** assert `rst` for 1 cycle while in WAIT, then deliver the stale `rvalid`. Required: it is ignored, `id_valid`=0, `id_inst`=0x00000013, and the fetch restarts at `pc`.
